// File: rtl/alt_div_1pt8.sv
// rtl/alt_div_1pt8.sv - restoring radix-2 divider computing din*256/461 (inverse of the x461/256 scaler)
// One quotient bit per clock; the quotient shifts into the dividend register as it is consumed.
module alt_div_1pt8 #(
  parameter int WIDTH = 8,
  parameter int ROUND = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic [8:0]       rem,
  output logic             busy
);

  localparam int DW = WIDTH + 8;
  localparam int CW = $clog2(DW);
  localparam logic [9:0] DIVISOR = 10'd461;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    dvd, dvd_nxt;
  logic [8:0]       prem, prem_nxt;
  logic [CW-1:0]    cnt;
  logic [9:0]       trial, diff, rem2;
  logic             q_bit, round_up, accept, last_iter, handoff;
  logic [WIDTH-1:0] q_fin;

  // Partial remainder stays below 461, so trial < 922 and the wrapped
  // difference has bit 9 set exactly when trial < 461.
  always_comb begin
    trial    = {prem, dvd[DW-1]};
    diff     = trial - DIVISOR;
    q_bit    = ~diff[9];
    prem_nxt = q_bit ? diff[8:0] : trial[8:0];
    dvd_nxt  = {dvd[DW-2:0], q_bit};
    rem2     = {prem_nxt, 1'b0};
    round_up = (ROUND != 0) && (rem2 >= DIVISOR);
    q_fin    = dvd_nxt[WIDTH-1:0] + WIDTH'(round_up);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = RUN;
      end
      RUN:  if (cnt == '0) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept    = (state == IDLE) && in_valid;
  assign last_iter = (state == RUN) && (cnt == '0);
  assign handoff   = (state == DONE) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd       <= '0;
      prem      <= '0;
      cnt       <= '0;
      dout      <= '0;
      rem       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        dvd  <= {din, 8'b0};
        prem <= '0;
        cnt  <= CW'(DW - 1);
      end else if (state == RUN) begin
        dvd  <= dvd_nxt;
        prem <= prem_nxt;
        cnt  <= cnt - CW'(1);
      end
      // Result registers only move on the final iteration, so they hold through DONE.
      if (last_iter) begin
        dout      <= q_fin;
        rem       <= prem_nxt;
        out_valid <= 1'b1;
      end else if (handoff) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alt_div_1pt8.sv
// tb/tb_alt_div_1pt8.sv - directed and exhaustive checks of alt_div_1pt8 for both ROUND settings
module tb_alt_div_1pt8;

  logic       clk, rst_n, in_valid, out_ready;
  logic [7:0] din;
  logic       in_ready0, out_valid0, busy0;
  logic       in_ready1, out_valid1, busy1;
  logic [7:0] dout0, dout1;
  logic [8:0] rem0, rem1;

  int checks = 0;
  int errors = 0;

  logic [7:0] r_dout0, r_dout1;
  logic [8:0] r_rem0, r_rem1;
  int         r_lat, r_irdy_hi;

  alt_div_1pt8 #(.WIDTH(8), .ROUND(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .din(din),
    .out_valid(out_valid0), .out_ready(out_ready), .dout(dout0), .rem(rem0), .busy(busy0)
  );

  alt_div_1pt8 #(.WIDTH(8), .ROUND(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .din(din),
    .out_valid(out_valid1), .out_ready(out_ready), .dout(dout1), .rem(rem1), .busy(busy1)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] v);
    int w;
    w = 0;
    while (!in_ready0 && w < 50) begin
      @(posedge clk); #1; w++;
    end
    chk("start_ready", in_ready0, 1);
    in_valid = 1'b1;
    din      = v;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    din       = 8'hA5;
    r_lat     = 0;
    r_irdy_hi = 0;
    while (!out_valid0 && r_lat < 40) begin
      if (in_ready0 || in_ready1) r_irdy_hi++;
      @(posedge clk); #1; r_lat++;
    end
    chk("valid_pair", out_valid1, out_valid0);
    r_dout0 = dout0; r_rem0 = rem0;
    r_dout1 = dout1; r_rem1 = rem1;
  endtask

  task automatic drain_random();
    logic sent;
    for (int n = 0; n < 8; n++) begin
      out_ready = (n >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
      sent = out_ready;
      @(posedge clk); #1;
      if (sent) break;
      chk("rnd_hold_valid", out_valid0, 1);
      chk("rnd_hold_dout", dout0, r_dout0);
      chk("rnd_hold_rem", rem1, r_rem1);
    end
    chk("rnd_drained", out_valid0, 0);
  endtask

  initial begin
    int qe, re, s0, s1;
    clk = 0; rst_n = 0; in_valid = 0; din = 0; out_ready = 1;

    #12;
    chk("rst_in_ready", in_ready0, 1);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_dout", dout1, 0);
    chk("rst_rem", rem0, 0);
    chk("rst_busy", busy0, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // din=255: latency, single-cycle valid, in_ready low throughout
    start_op(8'd255);
    chk("lat_255", r_lat, 16);
    chk("irdy_low_255", r_irdy_hi, 0);
    chk("busy_done", busy0, 1);
    chk("dout0_255", r_dout0, 141);
    chk("rem0_255", r_rem0, 279);
    chk("dout1_255", r_dout1, 142);
    chk("rem1_255", r_rem1, 279);
    @(posedge clk); #1;
    chk("valid_one_cycle", out_valid0, 0);
    chk("back_idle", in_ready0, 1);

    start_op(8'd100);
    chk("dout0_100", r_dout0, 55);
    chk("rem0_100", r_rem0, 245);
    chk("dout1_100", r_dout1, 56);
    @(posedge clk); #1;

    start_op(8'd1);
    chk("dout0_1", r_dout0, 0);
    chk("rem0_1", r_rem0, 256);
    chk("dout1_1", r_dout1, 1);
    @(posedge clk); #1;

    start_op(8'd0);
    chk("lat_0", r_lat, 16);
    chk("dout0_0", r_dout0, 0);
    chk("rem0_0", r_rem0, 0);
    chk("dout1_0", r_dout1, 0);
    @(posedge clk); #1;

    // Backpressure with ignored input pulses
    out_ready = 0;
    start_op(8'd100);
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      din      = 8'd7 + 8'(i);
      @(posedge clk); #1;
      chk("bp_valid", out_valid0, 1);
      chk("bp_dout0", dout0, 55);
      chk("bp_rem0", rem0, 245);
      chk("bp_dout1", dout1, 56);
      chk("bp_in_ready", in_ready0, 0);
    end
    in_valid  = 0;
    out_ready = 1;
    @(posedge clk); #1;
    chk("bp_release_valid", out_valid0, 0);
    chk("bp_release_idle", in_ready0, 1);
    start_op(8'd3);
    chk("dout0_3", r_dout0, 1);
    chk("rem0_3", r_rem0, 307);
    chk("dout1_3", r_dout1, 2);
    @(posedge clk); #1;

    // Asynchronous reset at RUN iteration 5
    in_valid = 1; din = 8'd77;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_busy", busy0, 1);
    rst_n = 0;
    #1;
    chk("arst_valid", out_valid0, 0);
    chk("arst_dout0", dout0, 0);
    chk("arst_dout1", dout1, 0);
    chk("arst_rem", rem0, 0);
    chk("arst_busy", busy1, 0);
    @(negedge clk) rst_n = 1;
    repeat (20) begin
      @(posedge clk); #1;
      chk("arst_no_output", out_valid0, 0);
    end
    start_op(8'd200);
    chk("dout0_200", r_dout0, 111);
    chk("rem0_200", r_rem0, 29);
    chk("dout1_200", r_dout1, 111);
    @(posedge clk); #1;

    // Exhaustive sweep with random output backpressure
    for (int v = 0; v < 256; v++) begin
      out_ready = 1'($urandom_range(0, 1));
      start_op(v[7:0]);
      qe = (v * 256) / 461;
      re = (v * 256) % 461;
      s0 = (int'(r_dout0) * 461) >> 8;
      s1 = (int'(r_dout1) * 461) >> 8;
      chk("ex_lat", r_lat, 16);
      chk("ex_dout0", r_dout0, qe);
      chk("ex_rem0", r_rem0, re);
      chk("ex_rem1", r_rem1, re);
      chk("ex_dout1", r_dout1, qe + ((2 * re >= 461) ? 1 : 0));
      chk("ex_identity", int'(r_dout0) * 461 + int'(r_rem0), v * 256);
      chk("ex_scale0", (s0 <= v) && (s0 + 2 >= v), 1);
      chk("ex_scale1", (s1 <= v + 1) && (s1 + 1 >= v), 1);
      drain_random();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
